// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - sequenced async SRAM controller (setup/strobe/hold/turnaround)
// Optional read/write parity on the bus MSB: define SRAM_CTRL_PARITY_EN.
module sram_mem_ctrl #(
    parameter int ADR_W       = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-2:0] wdata,
    output logic [DATA_W-2:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              par_err,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADR_W-1:0]  sram_adr,
    inout  wire  [DATA_W-1:0] mem_data
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_mem_ctrl: WAIT_CYCLES must be >= 1");
    end

    localparam int CMAX = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              op_we, op_we_nxt;
    logic              accept;
    logic              in_cycle_nxt;
    logic              capture;
    logic              drv;
    logic [DATA_W-1:0] dout;
    logic              wpar;

    assign accept    = (state == IDLE) && req;
    assign op_we_nxt = accept ? we : op_we;
    // Last ACCESS cycle: the edge ending it samples the SRAM output.
    assign capture   = (state == ACCESS) && (cnt == '0) && !op_we;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_we <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_we <= op_we_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
                cnt_nxt   = CW'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                if (TURN_CYCLES > 0) begin
                    state_nxt = TURN;
                    cnt_nxt   = CW'(TURN_CYCLES - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            TURN: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_cycle_nxt = (state_nxt == SETUP) || (state_nxt == ACCESS) || (state_nxt == DONE);

    // Strobes are decoded from the next state so each phase's outputs leave a flop.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
            drv       <= 1'b0;
            dout      <= '0;
            sram_adr  <= '0;
            rdata     <= '0;
        end else begin
            sram_ce_n <= !in_cycle_nxt;
            sram_oe_n <= !((state_nxt == ACCESS) && !op_we_nxt);
            sram_we_n <= !((state_nxt == ACCESS) && op_we_nxt);
            ready     <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            drv       <= in_cycle_nxt && op_we_nxt;
            if (accept) begin
                sram_adr <= adr;
                dout     <= {wpar, wdata};
            end
            if (capture) rdata <= mem_data[DATA_W-2:0];
        end
    end

    // Bus is driven only by writes, so it can never collide with oe_n low.
    assign mem_data = drv ? dout : {DATA_W{1'bz}};

`ifdef SRAM_CTRL_PARITY_EN
    logic par_q;

    assign wpar = ^wdata;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if ((state == ACCESS) && (cnt == '0)) begin
            par_q <= op_we ? 1'b0 : ^mem_data;
        end
    end

    assign par_err = par_q;
`else
    logic unused_par_bit;

    assign wpar           = 1'b0;
    assign par_err        = 1'b0;
    assign unused_par_bit = mem_data[DATA_W-1];
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed self-checking bench for sram_mem_ctrl with an SRAM model
module tb_sram_mem_ctrl;

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  adr = 8'h00;
    logic [14:0] wdata = 15'h0000;
    logic [14:0] rdata;
    logic        ready, busy, par_err;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [7:0]  sram_adr;
    wire  [15:0] mem_data;

    logic [15:0] mem [256] = '{default: 16'h0000};
    logic        flip_en = 1'b0;
    logic [7:0]  flip_adr = 8'h00;
    logic [15:0] flip_mask = 16'h0000;

    int vectors = 0;
    int miscompares = 0;

`ifdef SRAM_CTRL_PARITY_EN
    localparam logic [15:0] WEXP = 16'h9234;
    localparam logic [15:0] PEXP = 16'h8001;
    localparam logic        PERR = 1'b1;
`else
    localparam logic [15:0] WEXP = 16'h1234;
    localparam logic [15:0] PEXP = 16'h0001;
    localparam logic        PERR = 1'b0;
`endif

    sram_mem_ctrl dut (
        .clk1      (clk1),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .adr       (adr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .par_err   (par_err),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_adr  (sram_adr),
        .mem_data  (mem_data)
    );

    always #5 clk1 = ~clk1;

    assign mem_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 16'bz;

    always @(posedge clk1) begin
        if (flip_en) mem[flip_adr] <= mem[flip_adr] ^ flip_mask;
        else if (!sram_ce_n && !sram_we_n) mem[sram_adr] <= mem_data;
    end

    task automatic test_reset();
        #12;
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, ready, busy, par_err} !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {sram_ce_n, sram_oe_n, sram_we_n, ready, busy, par_err}, 6'b111000);
        end
        vectors++;
        if (rdata !== 15'h0 || sram_adr !== 8'h0 || $countones(mem_data) != 0) begin
            miscompares++;
            $display("FAIL reset_data: got rdata=%h adr=%h bus=%h expected 0/0/released",
                     rdata, sram_adr, mem_data);
        end
        @(negedge clk1);
        #1 reset = 1'b1;
    endtask

    task automatic test_abort();
        @(negedge clk1);
        req = 1'b1; we = 1'b1; adr = 8'h80; wdata = 15'h7E5A;
        @(posedge clk1);
        #1 req = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        vectors++;
        if (sram_we_n !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_access: got we_n=%b expected 0", sram_we_n);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, ready, busy} !== 5'b11100 || $countones(mem_data) != 0) begin
            miscompares++;
            $display("FAIL abort_immediate: got %b bus=%h expected 11100 released",
                     {sram_ce_n, sram_oe_n, sram_we_n, ready, busy}, mem_data);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk1);
            vectors++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_held: got ready=%b busy=%b expected 0 0", ready, busy);
            end
        end
        #1 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk1);
            vectors++;
            if (ready !== 1'b0 || sram_we_n !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_no_resume: got ready=%b we_n=%b expected 0 1", ready, sram_we_n);
            end
        end
        vectors++;
        if (mem[8'h80] !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_no_write: got %h expected 0000", mem[8'h80]);
        end
    endtask

    task automatic test_write();
        logic [4:0] exp_s [6] = '{5'b01101, 5'b01001, 5'b01001, 5'b01111, 5'b11101, 5'b11100};
        int we_low = 0;
        int rdy_at = 0;
        @(negedge clk1);
        req = 1'b1; we = 1'b1; adr = 8'h3C; wdata = 15'h1234;
        @(posedge clk1);
        #1 req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk1);
            vectors++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, ready, busy} !== exp_s[c-1]) begin
                miscompares++;
                $display("FAIL write_strobes c%0d: got %b expected %b", c,
                         {sram_ce_n, sram_oe_n, sram_we_n, ready, busy}, exp_s[c-1]);
            end
            vectors++;
            if (c <= 4) begin
                if (mem_data !== WEXP || sram_adr !== 8'h3C) begin
                    miscompares++;
                    $display("FAIL write_bus c%0d: got %h@%h expected %h@3c", c, mem_data, sram_adr, WEXP);
                end
            end else if ($countones(mem_data) != 0) begin
                miscompares++;
                $display("FAIL write_release c%0d: got %h expected released", c, mem_data);
            end
            if (!sram_we_n) we_low++;
            if (ready) rdy_at = c;
        end
        vectors++;
        if (we_low != 2 || rdy_at != 4) begin
            miscompares++;
            $display("FAIL write_timing: got we_low=%0d ready_at=%0d expected 2 4", we_low, rdy_at);
        end
        vectors++;
        if (mem[8'h3C] !== WEXP) begin
            miscompares++;
            $display("FAIL write_sram: got %h expected %h", mem[8'h3C], WEXP);
        end
    endtask

    task automatic test_read();
        logic [4:0] exp_s [6] = '{5'b01101, 5'b00101, 5'b00101, 5'b01111, 5'b11101, 5'b11100};
        @(negedge clk1);
        req = 1'b1; we = 1'b0; adr = 8'h3C;
        @(posedge clk1);
        #1 req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk1);
            vectors++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, ready, busy} !== exp_s[c-1]) begin
                miscompares++;
                $display("FAIL read_strobes c%0d: got %b expected %b", c,
                         {sram_ce_n, sram_oe_n, sram_we_n, ready, busy}, exp_s[c-1]);
            end
            vectors++;
            if (!sram_oe_n) begin
                if (!sram_we_n || mem_data !== mem[sram_adr]) begin
                    miscompares++;
                    $display("FAIL read_contention c%0d: got bus=%h we_n=%b expected %h 1",
                             c, mem_data, sram_we_n, mem[sram_adr]);
                end
            end else if ($countones(mem_data) != 0) begin
                miscompares++;
                $display("FAIL read_release c%0d: got %h expected released", c, mem_data);
            end
            if (c == 4 || c == 6) begin
                vectors++;
                if (rdata !== 15'h1234 || par_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_data c%0d: got %h par=%b expected 1234 0", c, rdata, par_err);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        ops_we  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  ops_adr [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};
        logic [14:0] ops_dat [8] = '{15'h7FFF, 15'h7FFF, 15'h0000, 15'h0000,
                                     15'h5555, 15'h5555, 15'h2AAA, 15'h2AAA};
        logic [2:0]  exp_s   [6] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b110, 3'b100};
        @(negedge clk1);
        req = 1'b1; we = ops_we[0]; adr = ops_adr[0]; wdata = ops_dat[0];
        @(posedge clk1);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                we = ops_we[i+1]; adr = ops_adr[i+1]; wdata = ops_dat[i+1];
            end else begin
                req = 1'b0;
            end
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk1);
                vectors++;
                if ({sram_ce_n, busy, ready} !== exp_s[c-1]) begin
                    miscompares++;
                    $display("FAIL b2b_cadence op%0d c%0d: got %b expected %b", i, c,
                             {sram_ce_n, busy, ready}, exp_s[c-1]);
                end
                if (c == 4 && !ops_we[i]) begin
                    vectors++;
                    if (rdata !== ops_dat[i] || par_err !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_rdata op%0d: got %h par=%b expected %h 0", i,
                                 rdata, par_err, ops_dat[i]);
                    end
                end
            end
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int n_ready = 0;
        int we_low = 0;
        @(negedge clk1);
        req = 1'b1; we = 1'b0; adr = 8'h02;
        @(posedge clk1);
        #1 req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk1);
            if (ready) n_ready++;
            if (!sram_we_n) we_low++;
            if (c == 2 || c == 5) begin
                req = 1'b1; we = 1'b1; adr = 8'h05; wdata = 15'h1111;
            end else begin
                req = 1'b0;
            end
        end
        vectors++;
        if (n_ready != 1 || we_low != 0) begin
            miscompares++;
            $display("FAIL busy_ignore: got ready_pulses=%0d we_low=%0d expected 1 0", n_ready, we_low);
        end
        vectors++;
        if (mem[8'h05] !== 16'h0000 || rdata !== 15'h5555) begin
            miscompares++;
            $display("FAIL busy_no_access: got mem=%h rdata=%h expected 0000 5555", mem[8'h05], rdata);
        end
    endtask

    task automatic test_parity();
        @(negedge clk1);
        req = 1'b1; we = 1'b1; adr = 8'h10; wdata = 15'h0001;
        @(posedge clk1);
        #1 req = 1'b0;
        repeat (6) @(negedge clk1);
        vectors++;
        if (mem[8'h10] !== PEXP) begin
            miscompares++;
            $display("FAIL parity_write: got %h expected %h", mem[8'h10], PEXP);
        end
        flip_adr = 8'h10; flip_mask = 16'h0008; flip_en = 1'b1;
        @(posedge clk1);
        #1 flip_en = 1'b0;
        @(negedge clk1);
        req = 1'b1; we = 1'b0; adr = 8'h10;
        @(posedge clk1);
        #1 req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk1);
            if (c == 4 || c == 6) begin
                vectors++;
                if (rdata !== 15'h0009 || par_err !== PERR || ready !== (c == 4)) begin
                    miscompares++;
                    $display("FAIL parity_read c%0d: got %h par=%b rdy=%b expected 0009 %b %b", c,
                             rdata, par_err, ready, PERR, (c == 4));
                end
            end
        end
        @(negedge clk1);
        req = 1'b1; we = 1'b0; adr = 8'h3C;
        @(posedge clk1);
        #1 req = 1'b0;
        repeat (4) @(negedge clk1);
        vectors++;
        if (rdata !== 15'h1234 || par_err !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_clear: got %h par=%b rdy=%b expected 1234 0 1", rdata, par_err, ready);
        end
        repeat (2) @(negedge clk1);
    endtask

    initial begin
        test_reset();
        test_abort();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_ignore();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
